// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving the J/K inputs of an external bank of JK flip-flops.
// Applies LOAD/UP/DOWN/CLEAR for cmd_len steps, reading the bank back through q_fb.
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_UP, OP_DOWN, OP_CLEAR} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] up_t, dn_t;

  // Bit i toggles when all lower bits are ones (count up) or all zeros (count down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_fb[i-1];
      dn_t[i] = dn_t[i-1] & ~q_fb[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    j         = '0;
    k         = '0;
    done      = 1'b0;
    wrap      = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            op_d    = op_t'(cmd_op);
            data_d  = cmd_data;
            cnt_d   = cmd_len;
            state_d = (cmd_len == 4'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_d = DONE;
          end else begin
            case (op_q)
              OP_LOAD: begin
                j = data_q;
                k = ~data_q;
              end
              OP_UP: begin
                j    = up_t;
                k    = up_t;
                wrap = &q_fb;
              end
              OP_DOWN: begin
                j    = dn_t;
                k    = dn_t;
                wrap = ~|q_fb;
              end
              OP_CLEAR: begin
                j = '0;
                k = '1;
              end
              default: begin
                j = '0;
                k = '0;
              end
            endcase
            cnt_d = cnt_q - 4'd1;
            // The step applied at this edge is the last one when one remains.
            if (cnt_q == 4'd1) state_d = DONE;
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a JK flip-flop bank closes the loop, an arithmetic
// model of the counter is compared every cycle, and directed scenarios pin literals.
module tb_jk_bank_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [W-1:0] cmd_data = '0;
  logic [3:0]   cmd_len = 4'd0;
  logic         abort = 1'b0;
  logic [W-1:0] q_fb = '0;
  logic [W-1:0] j, k;
  logic         busy, done, wrap;

  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;
  logic         chk_en = 1'b0;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .abort(abort),
    .q_fb(q_fb), .j(j), .k(k), .busy(busy), .done(done), .wrap(wrap)
  );

  // The external flip-flop bank, with a preload path used only between commands.
  always @(posedge clk) begin
    if (preset_en) q_fb <= preset_val;
    else           q_fb <= (j & ~q_fb) | (~k & q_fb);
  end

  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t      m_phase = M_IDLE;
  logic [1:0]   m_op = 2'd0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_q = '0;
  int           m_left = 0;

  function automatic logic [W-1:0] nextValue(input logic [1:0] op, input logic [W-1:0] data,
                                             input logic [W-1:0] q);
    logic [W-1:0] one;
    one = 1;
    case (op)
      2'd0:    return data;
      2'd1:    return q + one;
      2'd2:    return q - one;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (preset_en) m_q = preset_val;
    if (rst) begin
      m_phase = M_IDLE;
      m_left  = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (cmd_valid) begin
          m_op    = cmd_op;
          m_data  = cmd_data;
          m_left  = int'(cmd_len);
          m_phase = (cmd_len == 4'd0) ? M_DONE : M_RUN;
        end
        M_RUN: if (abort) begin
          m_phase = M_DONE;
        end else begin
          m_q    = nextValue(m_op, m_data, m_q);
          m_left = m_left - 1;
          if (m_left == 0) m_phase = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison: J/K are the bits that differ between the count and its successor.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] ej, ek, one;
      logic         ewrap;
      one   = 1;
      ej    = '0;
      ek    = '0;
      ewrap = 1'b0;
      if (!rst && m_phase == M_RUN && !abort) begin
        case (m_op)
          2'd0: begin ej = m_data; ek = ~m_data; end
          2'd1: begin ej = m_q ^ (m_q + one); ek = ej; ewrap = (m_q == '1); end
          2'd2: begin ej = m_q ^ (m_q - one); ek = ej; ewrap = (m_q == '0); end
          default: begin ej = '0; ek = '1; end
        endcase
      end
      checkOutput("model_cmd_ready", cmd_ready, !rst && m_phase == M_IDLE);
      checkOutput("model_busy", busy, !rst && m_phase != M_IDLE);
      checkOutput("model_done", done, !rst && m_phase == M_DONE);
      checkOutput("model_wrap", wrap, ewrap);
      checkOutput("model_j", j, ej);
      checkOutput("model_k", k, ek);
      checkOutput("model_q_fb", q_fb, m_q);
    end
  end

  int           obs_busy, obs_done, obs_done_idx, obs_wrap, obs_wrap_idx;
  logic [W-1:0] obs_j[16];
  logic [W-1:0] obs_k[16];
  logic [W-1:0] obs_jk_or;

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic presetBank(input logic [W-1:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    stepCycle();
    preset_en  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data, input logic [3:0] len);
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    stepCycle();
    cmd_valid = 1'b0;
  endtask

  task automatic observe(input int n, input int abort_at);
    obs_busy = 0; obs_done = 0; obs_done_idx = -1;
    obs_wrap = 0; obs_wrap_idx = -1; obs_jk_or = '0;
    for (int i = 0; i < n; i++) begin
      abort = (i == abort_at);
      @(negedge clk);
      if (busy) obs_busy++;
      if (done) begin obs_done++; if (obs_done_idx < 0) obs_done_idx = i; end
      if (wrap) begin obs_wrap++; if (obs_wrap_idx < 0) obs_wrap_idx = i; end
      obs_j[i] = j;
      obs_k[i] = k;
      obs_jk_or |= (j | k);
      stepCycle();
    end
    abort = 1'b0;
  endtask

  initial begin
    stepCycle();
    chk_en = 1'b1;
    stepCycle();
    @(negedge clk);
    checkOutput("reset_outputs", {cmd_ready, busy, done, wrap, j, k}, '0);
    stepCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", cmd_ready, 1);
    stepCycle();

    presetBank(4'b0000);
    applyStimulus(2'd1, 4'd0, 4'd3);
    observe(6, -1);
    checkOutput("up3_q", q_fb, 4'b0011);
    checkOutput("up3_busy_cycles", obs_busy, 4);
    checkOutput("up3_done_pulses", obs_done, 1);

    presetBank(4'b1110);
    applyStimulus(2'd1, 4'd0, 4'd3);
    observe(6, -1);
    checkOutput("upwrap_q", q_fb, 4'b0001);
    checkOutput("upwrap_count", obs_wrap, 1);
    checkOutput("upwrap_idx", obs_wrap_idx, 1);

    presetBank(4'b0000);
    applyStimulus(2'd2, 4'd0, 4'd1);
    observe(3, -1);
    checkOutput("down_q", q_fb, 4'b1111);
    checkOutput("down_wrap", obs_wrap, 1);
    applyStimulus(2'd0, 4'b1010, 4'd1);
    observe(3, -1);
    checkOutput("load_j", obs_j[0], 4'b1010);
    checkOutput("load_k", obs_k[0], 4'b0101);
    checkOutput("load_q", q_fb, 4'b1010);

    presetBank(4'b1001);
    applyStimulus(2'd3, 4'd0, 4'd2);
    observe(4, -1);
    checkOutput("clear_jk", {obs_j[0], obs_k[0]}, 8'b0000_1111);
    checkOutput("clear_q", q_fb, 4'b0000);

    presetBank(4'b0000);
    applyStimulus(2'd1, 4'd0, 4'd10);
    observe(6, 2);
    checkOutput("abort_q", q_fb, 4'b0010);
    checkOutput("abort_jk", {obs_j[2], obs_k[2]}, 8'h00);
    checkOutput("abort_done_idx", obs_done_idx, 3);

    presetBank(4'b0101);
    applyStimulus(2'd1, 4'd0, 4'd0);
    observe(3, -1);
    checkOutput("len0_done_idx", obs_done_idx, 0);
    checkOutput("len0_busy", obs_busy, 1);
    checkOutput("len0_jk", obs_jk_or, 4'b0000);
    checkOutput("len0_q", q_fb, 4'b0101);

    presetBank(4'b0000);
    applyStimulus(2'd1, 4'd0, 4'd10);
    observe(2, -1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrun_rst_outputs", {cmd_ready, busy, done, wrap, j, k}, '0);
    stepCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", cmd_ready, 1);
    checkOutput("post_rst_q", q_fb, 4'b0010);
    stepCycle();
    applyStimulus(2'd0, 4'b0110, 4'd1);
    observe(3, -1);
    checkOutput("post_rst_load_q", q_fb, 4'b0110);
    checkOutput("post_rst_done", obs_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
